// File: rtl/product_display.sv
// product_display: latches the signed product on a rising edge of `done`,
// converts its magnitude to five BCD digits with a sequential double-dabble
// (one bit per cycle), then scans an 8-digit active-low seven-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros and
// float the minus sign next to the most significant shown digit.
module product_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [15:0] product,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] RCNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [3:0] GLYPH_MINUS = 4'hA;
    localparam logic [3:0] GLYPH_BLANK = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SHOW
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             done_q;
    logic             capture;
    logic [15:0]      bin;
    logic [19:0]      bcd;
    logic [19:0]      bcd_adj;
    logic [4:0]       iter;
    logic             neg;
    logic [2:0]       idx;
    logic [CNT_W-1:0] rcnt;
    logic [3:0]       cur_digit;
    logic [3:0]       glyph;

    assign capture = done & ~done_q;

    // Segment code for a glyph (active-low, gfedcba).
    function automatic logic [6:0] seg_of(input logic [3:0] g);
        case (g)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            4'hA:    seg_of = 7'h3F;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    // Edge-detect history; it tracks done even in reset so a level held
    // across reset is not mistaken for a new rising edge.
    always_ff @(posedge clk) begin
        // NOTE: registers take <= so every flop samples pre-edge values;
        // blocking = here would create order-dependent simulation races.
        done_q <= done;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a capture always wins and (re)starts a conversion.
    always_comb begin
        // NOTE: default first so every path assigns state_next; a missing
        // branch would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = CONVERT;
            CONVERT: begin
                if (capture)           state_next = CONVERT;
                else if (iter == 5'd15) state_next = SHOW;
            end
            SHOW:    if (capture) state_next = CONVERT;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD nibble of 5 or more.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Datapath: capture, conversion shifts and refresh scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin  <= '0;
            bcd  <= '0;
            iter <= '0;
            neg  <= 1'b0;
            idx  <= '0;
            rcnt <= '0;
        end else if (capture) begin
            neg  <= product[15];
            bin  <= product[15] ? -product : product;
            bcd  <= '0;
            iter <= '0;
            idx  <= '0;
            rcnt <= '0;
        end else if (state == CONVERT) begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
            iter       <= iter + 5'd1;
        end else if (state == SHOW) begin
            if (rcnt == RCNT_LAST) begin
                rcnt <= '0;
                idx  <= idx + 3'd1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end

    // BCD digit under the scan index (zero beyond the five magnitude digits).
    always_comb begin
        cur_digit = 4'd0;
        case (idx)
            3'd0:    cur_digit = bcd[3:0];
            3'd1:    cur_digit = bcd[7:4];
            3'd2:    cur_digit = bcd[11:8];
            3'd3:    cur_digit = bcd[15:12];
            3'd4:    cur_digit = bcd[19:16];
            default: cur_digit = 4'd0;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] msd;

    // Glyph selection with leading-zero blanking and a floating minus sign.
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = 3'(i);
        end
        if (idx <= msd)                   glyph = cur_digit;
        else if (neg && idx == msd + 3'd1) glyph = GLYPH_MINUS;
        else                               glyph = GLYPH_BLANK;
    end
`else
    // Glyph selection: five digits with leading zeros, sign in digit 5.
    always_comb begin
        glyph = GLYPH_BLANK;
        if (idx <= 3'd4)               glyph = cur_digit;
        else if (idx == 3'd5 && neg)   glyph = GLYPH_MINUS;
    end
`endif

    // Status and display drive; the display is blank unless showing a result.
    always_comb begin
        busy  = (state == CONVERT);
        valid = (state == SHOW);
        an    = 8'hFF;
        seg   = 7'h7F;
        if (valid) begin
            an  = ~(8'b1 << idx);
            seg = seg_of(glyph);
        end
    end

endmodule

// File: tb/tb_product_display.sv
// Self-checking bench for product_display (REFRESH_DIV = 4). The expected
// display is derived from the product value with decimal arithmetic.
module tb_product_display;

    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done = 1'b0;
    logic [15:0] product = 16'h0000;
    logic        busy;
    logic        valid;
    logic [7:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad   = 0;

    product_display #(.REFRESH_DIV(RDIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .done    (done),
        .product (product),
        .busy    (busy),
        .valid   (valid),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] digit_code(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    // Reference: expected segments at a digit position for a given product.
    function automatic logic [6:0] exp_seg(input logic [15:0] p, input int pos);
        logic signed [15:0] ps;
        int v, mag, t, msd;
        int d [5];
        bit neg;
        ps  = p;
        v   = ps;
        neg = (v < 0);
        mag = neg ? -v : v;
        t   = mag;
        msd = 0;
        for (int i = 0; i < 5; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            if (d[i] != 0) msd = i;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (pos <= msd) return digit_code(d[pos]);
        if (neg && pos == msd + 1) return 7'h3F;
        return 7'h7F;
`else
        if (pos < 5) return digit_code(d[pos]);
        if (pos == 5 && neg) return 7'h3F;
        return 7'h7F;
`endif
    endfunction

    // Produce a clean 0->1 on done; returns right after the capture edge.
    task automatic capture(input logic [15:0] p);
        done = 1'b0;
        step();
        product = p;
        done = 1'b1;
        step();
        check("cap_busy", busy, 1'b1);
        check("cap_valid", valid, 1'b0);
        done = 1'b0;
    endtask

    // Count edges from the capture edge until valid, bounded.
    task automatic wait_valid();
        int lat = 0;
        int exclusive_err = 0;
        while (lat < 40) begin
            step();
            lat++;
            if ((busy ^ valid) !== 1'b1) exclusive_err++;
            if (valid === 1'b1) break;
        end
        check("latency", lat, 16);
        check("busy_valid_exclusive", exclusive_err, 0);
        check("busy_after", busy, 1'b0);
    endtask

    // Walk one full frame from index 0, checking every cycle, then the wrap.
    task automatic check_display(input logic [15:0] p);
        logic [7:0] ea;
        logic [6:0] es;
        for (int pos = 0; pos < 8; pos++) begin
            for (int c = 0; c < RDIV; c++) begin
                ea = ~(8'b1 << pos);
                es = exp_seg(p, pos);
                check($sformatf("an p=%h pos=%0d c=%0d", p, pos, c), an, ea);
                check($sformatf("seg p=%h pos=%0d c=%0d", p, pos, c), seg, es);
                step();
            end
        end
        check("an_wrap", an, 8'hFE);
        check("seg_wrap", seg, exp_seg(p, 0));
    endtask

    initial begin
        logic [15:0] rp;
        int early;

        // Reset held with done high.
        rst  = 1'b1;
        done = 1'b1;
        repeat (3) step();
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", valid, 1'b0);
        rst = 1'b0;
        repeat (3) step();
        check("no_cap_busy", busy, 1'b0);
        check("no_cap_valid", valid, 1'b0);
        check("no_cap_an", an, 8'hFF);

        // Directed products.
        capture(16'h0000); wait_valid(); check_display(16'h0000);
        capture(16'hFFC8); wait_valid(); check_display(16'hFFC8);
        capture(16'h4000); wait_valid(); check_display(16'h4000);
        capture(16'h8000); wait_valid(); check_display(16'h8000);
        capture(16'h7FFF); wait_valid(); check_display(16'h7FFF);

        // Held done level does not retrigger.
        done = 1'b1;
        step(); step();
        check("held_cap", busy, 1'b1);
        done = 1'b1;
        repeat (20) step();
        check("held_no_retrigger_valid", valid, 1'b1);
        check("held_no_retrigger_busy", busy, 1'b0);
        done = 1'b0;

        // Retrigger on the 5th iteration edge.
        capture(16'h0001);
        early = 0;
        repeat (4) begin
            step();
            if (valid !== 1'b0) early++;
        end
        product = 16'h007B;
        done = 1'b1;
        step();
        check("retrig_busy", busy, 1'b1);
        check("retrig_early_valid", early, 0);
        done = 1'b0;
        wait_valid();
        check_display(16'h007B);

        // Reset mid-scan.
        repeat (5) step();
        rst = 1'b1;
        step();
        check("midscan_an", an, 8'hFF);
        check("midscan_seg", seg, 7'h7F);
        check("midscan_busy", busy, 1'b0);
        check("midscan_valid", valid, 1'b0);
        rst = 1'b0;
        repeat (2) step();
        check("post_rst_valid", valid, 1'b0);

        // Reset mid-conversion discards the pending product.
        capture(16'h1234);
        repeat (7) step();
        rst = 1'b1;
        step();
        check("midconv_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (20) step();
        check("midconv_discard", valid, 1'b0);

        // Randomized products.
        for (int n = 0; n < 10; n++) begin
            rp = 16'($urandom);
            capture(rp);
            wait_valid();
            check_display(rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
